jtag_master: RTL and testbench

//  Host-side JTAG driver: turns IR-shift, DR-shift, reset and idle commands into TCK/TMS/TDI

---
 rtl/jtag_pkg.sv | 43 ++++
 rtl/jtag_tap_mirror.sv | 49 ++++
 rtl/jtag_master.sv | 176 +++++++++++++++++
 tb/tb_jtag_master.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encodings, command opcodes and master FSM states
// shared by the JTAG master and its TAP mirror.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_EX2_DR = 4'd0,
    TAP_EX1_DR = 4'd1,
    TAP_SH_DR  = 4'd2,
    TAP_PAU_DR = 4'd3,
    TAP_SEL_IR = 4'd4,
    TAP_UPD_DR = 4'd5,
    TAP_CAP_DR = 4'd6,
    TAP_SEL_DR = 4'd7,
    TAP_EX2_IR = 4'd8,
    TAP_EX1_IR = 4'd9,
    TAP_SH_IR  = 4'd10,
    TAP_PAU_IR = 4'd11,
    TAP_RTI    = 4'd12,
    TAP_UPD_IR = 4'd13,
    TAP_CAP_IR = 4'd14,
    TAP_TLR    = 4'd15
  } tap_state_e;

  typedef enum logic [1:0] {
    OP_RESET = 2'd0,
    OP_IR    = 2'd1,
    OP_DR    = 2'd2,
    OP_IDLE  = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    M_INIT,
    M_IDLE,
    M_PRE,
    M_SHIFT,
    M_POST,
    M_RUN,
    M_RSP
  } m_state_e;

  localparam int INIT_STEPS = 6;

endpackage

// File: rtl/jtag_tap_mirror.sv
// jtag_tap_mirror: tracks the target TAP state from the TMS value
// presented on each TCK high phase.
module jtag_tap_mirror
  import jtag_pkg::*;
(
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       i_step,
  input  logic       i_tms,
  output tap_state_e o_state
);

  tap_state_e r_state;
  tap_state_e w_next;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      TAP_TLR:    w_next = i_tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    w_next = i_tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: w_next = i_tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: w_next = i_tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  w_next = i_tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: w_next = i_tms ? TAP_UPD_DR : TAP_PAU_DR;
      TAP_PAU_DR: w_next = i_tms ? TAP_EX2_DR : TAP_PAU_DR;
      TAP_EX2_DR: w_next = i_tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: w_next = i_tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: w_next = i_tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: w_next = i_tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  w_next = i_tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: w_next = i_tms ? TAP_UPD_IR : TAP_PAU_IR;
      TAP_PAU_IR: w_next = i_tms ? TAP_EX2_IR : TAP_PAU_IR;
      TAP_EX2_IR: w_next = i_tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: w_next = i_tms ? TAP_SEL_DR : TAP_RTI;
      default:    w_next = TAP_TLR;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= TAP_TLR;
    end else if (i_step) begin
      r_state <= w_next;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/jtag_master.sv
// jtag_master: host-side JTAG driver, TCK = CLK/2, low phase then high phase.
// Optional JTAG_STATE_MIRROR_EN exposes tap_state and checks RTI in idle.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
`ifdef JTAG_STATE_MIRROR_EN
  output logic [3:0]         tap_state,
`endif
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;
  localparam logic [LEN_W-1:0] MAX_N = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_STEPS - 1);

  m_state_e           r_state;
  m_state_e           w_nstate;
  logic               r_ph;
  logic [CNT_W-1:0]   r_cnt;
  logic [LEN_W-1:0]   r_len;
  logic               r_ir;
  logic [MAX_LEN-1:0] r_data;
  logic [MAX_LEN-1:0] r_rsp;

  logic               w_step;
  logic               w_tms;
  logic               w_tdi;
  logic               w_done;
  logic               w_accept;
  logic [CNT_W-1:0]   w_last;
  logic [CNT_W-1:0]   w_nm1;
  logic [LEN_W-1:0]   w_len;
  logic [IDX_W-1:0]   w_idx;
  tap_state_e         w_tap;

  assign w_len    = (cmd_len > MAX_N) ? MAX_N : cmd_len;
  assign w_nm1    = CNT_W'(r_len) - CNT_W'(1);
  assign w_idx    = r_cnt[IDX_W-1:0];
  assign w_accept = (r_state == M_IDLE) && cmd_valid;
  assign w_done   = w_step && r_ph && (r_cnt == w_last);

  // Step decode: which states toggle TCK and what TMS/TDI each step carries.
  always_comb begin
    w_step = 1'b0;
    w_tms  = 1'b0;
    w_tdi  = 1'b0;
    w_last = '0;
    unique case (r_state)
      M_INIT: begin
        w_step = 1'b1;
        w_tms  = (r_cnt != INIT_LAST);
        w_last = INIT_LAST;
      end
      M_PRE: begin
        w_step = 1'b1;
        w_tms  = (r_cnt == '0) || (r_ir && r_cnt == CNT_W'(1));
        w_last = r_ir ? CNT_W'(3) : CNT_W'(2);
      end
      M_SHIFT: begin
        w_step = 1'b1;
        w_tms  = (r_cnt == w_nm1);
        w_tdi  = r_data[w_idx];
        w_last = w_nm1;
      end
      M_POST: begin
        w_step = 1'b1;
        w_tms  = (r_cnt == '0);
        w_last = CNT_W'(1);
      end
      M_RUN: begin
        w_step = 1'b1;
        w_last = w_nm1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      M_INIT:  if (w_done) w_nstate = M_IDLE;
      M_IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op_e'(cmd_op))
            OP_RESET: w_nstate = M_INIT;
            OP_IR,
            OP_DR:    w_nstate = (w_len == '0) ? M_RSP : M_PRE;
            OP_IDLE:  w_nstate = (w_len == '0) ? M_IDLE : M_RUN;
            default:  w_nstate = M_IDLE;
          endcase
        end
      end
      M_PRE:   if (w_done) w_nstate = M_SHIFT;
      M_SHIFT: if (w_done) w_nstate = M_POST;
      M_POST:  if (w_done) w_nstate = M_RSP;
      M_RUN:   if (w_done) w_nstate = M_IDLE;
      M_RSP:   if (rsp_ready) w_nstate = M_IDLE;
      default: w_nstate = M_INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= M_INIT;
      r_ph    <= 1'b0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_ir    <= 1'b0;
      r_data  <= '0;
      r_rsp   <= '0;
    end else begin
      r_state <= w_nstate;
      if (w_accept) begin
        r_len  <= w_len;
        r_ir   <= (cmd_op == OP_IR);
        r_data <= cmd_data;
        r_rsp  <= '0;
        r_cnt  <= '0;
        r_ph   <= 1'b0;
      end else if (w_step) begin
        r_ph <= ~r_ph;
        if (r_ph) begin
          r_cnt <= w_done ? '0 : r_cnt + CNT_W'(1);
        end
        if (r_ph && r_state == M_SHIFT) begin
          r_rsp[w_idx] <= tdo;
        end
      end
    end
  end

  assign cmd_ready = (r_state == M_IDLE);
  assign rsp_valid = (r_state == M_RSP);
  assign rsp_data  = r_rsp;
  assign tck       = w_step & r_ph;
  assign tms       = w_tms;
  assign tdi       = w_tdi;

  jtag_tap_mirror u_mirror (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .i_step  (tck),
    .i_tms   (tms),
    .o_state (w_tap)
  );

`ifdef JTAG_STATE_MIRROR_EN
  assign tap_state = w_tap;

  a_idle_in_rti: assert property (
    @(posedge CLK) disable iff (!RESETN)
    (r_state == M_IDLE) |-> (w_tap == TAP_RTI)
  );
`else
  logic w_unused_tap;
  assign w_unused_tap = ^w_tap;
`endif

endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: table-driven command vectors plus reset, backpressure
// and mid-command reset sequences for jtag_master.
module tb_jtag_master;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        tck;
  logic        tms;
  logic        tdi;
  logic        tdo;
  logic        tdo_inv;

  int n_run  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  assign tdo = tdo_inv ^ tdi;

  jtag_master dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo)
  );

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  len;
    logic [31:0] data;
    logic        inv;
    bit          exp_rsp;
    logic [31:0] exp_data;
    int          exp_pulses;
    logic [63:0] exp_tms;
    logic [63:0] exp_tdi;
    int          exp_cyc;
    int          hold;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(
    input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
    input logic inv, input bit er, input logic [31:0] ed, input int ep,
    input logic [63:0] et, input logic [63:0] ei, input int ec, input int h);
    vec_t v;
    v.op = op; v.len = len; v.data = data; v.inv = inv;
    v.exp_rsp = er; v.exp_data = ed; v.exp_pulses = ep;
    v.exp_tms = et; v.exp_tdi = ei; v.exp_cyc = ec; v.hold = h;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] len,
                       input logic [31:0] data, input logic inv);
    for (int k = 0; k < 200 && !cmd_ready; k++) @(negedge CLK);
    if (!cmd_ready) chk("issue_ready", cmd_ready, 1);
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    tdo_inv   = inv;
    cmd_valid = 1'b1;
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic monitor(output int p, output logic [63:0] ts,
                         output logic [63:0] td, output int cyc,
                         output bit saw);
    p = 0; ts = '0; td = '0; cyc = 0; saw = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      cyc++;
      if (tck) begin
        if (p < 64) begin
          ts[p] = tms;
          td[p] = tdi;
        end
        p++;
      end
      if (rsp_valid) saw = 1;
      if (rsp_valid || cmd_ready) break;
    end
    chk("mon_done", rsp_valid | cmd_ready, 1);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int p, cyc;
    logic [63:0] ts, td;
    bit saw, bad;
    logic [31:0] d0;
    issue(v.op, v.len, v.data, v.inv);
    monitor(p, ts, td, cyc, saw);
    chk($sformatf("v%0d_cycles", i), cyc, v.exp_cyc);
    chk($sformatf("v%0d_pulses", i), p, v.exp_pulses);
    chk($sformatf("v%0d_tms", i), ts, v.exp_tms);
    chk($sformatf("v%0d_tdi", i), td, v.exp_tdi);
    chk($sformatf("v%0d_rsp", i), saw, v.exp_rsp);
    if (saw) begin
      chk($sformatf("v%0d_data", i), rsp_data, v.exp_data);
      d0 = rsp_data;
      bad = 0;
      for (int h = 0; h < v.hold; h++) begin
        @(negedge CLK);
        if (!rsp_valid || rsp_data !== d0 || cmd_ready) bad = 1;
      end
      if (v.hold > 0) chk($sformatf("v%0d_hold", i), bad, 0);
      rsp_ready = 1'b1;
      @(posedge CLK);
      #1 rsp_ready = 1'b0;
      @(negedge CLK);
      chk($sformatf("v%0d_release", i), {rsp_valid, cmd_ready}, 2'b01);
    end
  endtask

  task automatic check_init(input string nm);
    int p, cyc;
    logic [63:0] ts, td;
    bit saw;
    monitor(p, ts, td, cyc, saw);
    chk({nm, "_pulses"}, p, 6);
    chk({nm, "_tms"}, ts, 64'h1F);
    chk({nm, "_tdi"}, td, 0);
    chk({nm, "_cycles"}, cyc, 12);
    chk({nm, "_ready"}, {saw, cmd_ready}, 2'b01);
  endtask

  initial begin
    int hits;
    bit bad;
    vecs[0] = mk(2'd1, 6'd4,  32'hA,        1'b0, 1, 32'hA,        10,
                 64'h183, 64'hA0, 21, 0);
    vecs[1] = mk(2'd2, 6'd8,  32'h5A,       1'b1, 1, 32'hA5,       13,
                 64'hC01, 64'h2D0, 27, 10);
    vecs[2] = mk(2'd3, 6'd3,  32'hFF,       1'b0, 0, 32'h0,        3,
                 64'h0, 64'h0, 7, 0);
    vecs[3] = mk(2'd2, 6'd0,  32'hFFFFFFFF, 1'b1, 1, 32'h0,        0,
                 64'h0, 64'h0, 1, 0);
    vecs[4] = mk(2'd3, 6'd0,  32'h0,        1'b0, 0, 32'h0,        0,
                 64'h0, 64'h0, 1, 0);
    vecs[5] = mk(2'd0, 6'd9,  32'h0,        1'b0, 0, 32'h0,        6,
                 64'h1F, 64'h0, 13, 0);
    vecs[6] = mk(2'd2, 6'd40, 32'h12345678, 1'b1, 1, 32'hEDCBA987, 37,
                 64'h0000_000C_0000_0001, 64'h0000_0000_91A2_B3C0, 75, 2);
    vecs[7] = mk(2'd1, 6'd1,  32'h1,        1'b0, 1, 32'h1,        7,
                 64'h33, 64'h10, 15, 0);
    vecs[8] = mk(2'd1, 6'd5,  32'h15,       1'b1, 1, 32'h0A,       11,
                 64'h303, 64'h150, 23, 0);

    RESETN    = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_len   = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    tdo_inv   = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_tck", tck, 0);
    chk("rst_tms", tms, 1);
    chk("rst_tdi", tdi, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    RESETN = 1'b1;
    check_init("init");

    foreach (vecs[i]) run_vec(i, vecs[i]);

    bad = 0;
    rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      if (rsp_valid || !cmd_ready) bad = 1;
    end
    rsp_ready = 1'b0;
    chk("idle_rsp_ready", bad, 0);

    issue(2'd2, 6'd8, 32'h5A, 1'b1);
    hits = 0;
    for (int k = 0; k < 100 && hits < 6; k++) begin
      @(negedge CLK);
      if (tck) hits++;
    end
    chk("mid_hits", hits, 6);
    RESETN = 1'b0;
    #1;
    chk("mid_tck", tck, 0);
    chk("mid_tms", tms, 1);
    chk("mid_tdi", tdi, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_cmd_ready", cmd_ready, 0);
    chk("mid_rsp_data", rsp_data, 0);
    repeat (3) @(negedge CLK);
    RESETN = 1'b1;
    check_init("reinit");

    run_vec(9, vecs[1]);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
